// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// One byte per frame: latch winner, pulse TxEn, await TxDone, ack, then gap.
module uart_tx_arbiter #(
   parameter int NREQ       = 2,
   parameter int GAP_CYCLES = 16,
   parameter int TIMEOUT    = 131072
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [NREQ-1:0]   Req,
   input  logic [8*NREQ-1:0] ReqData,
   output logic [NREQ-1:0]   Ack,
   output logic              TxEn,
   output logic [7:0]        TxData,
   input  logic              TxDone,
   output logic              Busy,
   output logic [2:0]        Owner,
   output logic              Err
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_GAP
   } state_t;

   state_t          state;
   logic [2:0]      ptr;
   logic [TW-1:0]   tcnt;
   logic [GW-1:0]   gcnt;

   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] rot;
   logic [3:0]      off;
   logic [3:0]      sum;
   logic            any_elig;
   logic [2:0]      win;
   logic [2:0]      nxt_ptr;

   // Pick the first eligible requester at or after ptr, wrapping at NREQ.
   always_comb begin
      elig     = Req & ~Ack;
      rot      = NREQ'({elig, elig} >> ptr);
      any_elig = |rot;
      off      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if ((rot & (NREQ'(1) << k)) != '0) off = 4'(k);
      end
      sum = {1'b0, ptr} + off;
      if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
      win     = sum[2:0];
      nxt_ptr = (Owner == 3'(NREQ - 1)) ? 3'd0 : Owner + 3'd1;
   end

   // Frame sequencer: grant, start pulse, completion/timeout wait, inter-frame gap.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state  <= S_IDLE;
         ptr    <= '0;
         tcnt   <= '0;
         gcnt   <= '0;
         Ack    <= '0;
         TxEn   <= 1'b0;
         TxData <= 8'h00;
         Busy   <= 1'b0;
         Owner  <= '0;
         Err    <= 1'b0;
      end else begin
         TxEn <= 1'b0;
         Ack  <= '0;
         Err  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (any_elig) begin
                  TxData <= 8'(ReqData >> {win, 3'b000});
                  Owner  <= win;
                  Busy   <= 1'b1;
                  TxEn   <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               tcnt  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (TxDone || (TIMEOUT > 0 && tcnt == T_LAST)) begin
                  if (TxDone) Ack <= NREQ'(1) << Owner;
                  else        Err <= 1'b1;
                  ptr  <= nxt_ptr;
                  gcnt <= '0;
                  if (GAP_CYCLES == 0) begin
                     Busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     state <= S_GAP;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            S_GAP: begin
               if (gcnt == G_LAST) begin
                  Busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timestamp-based frame model plus directed cases.
// Random requesters and TxDone pulses exercise arbitration, gap and timeout.
module tb_uart_tx_arbiter;

   localparam int NREQ = 3;
   localparam int GAP  = 16;
   localparam int TMO  = 100;

   logic              Clk = 1'b0;
   logic              Rst_n = 1'b0;
   logic [NREQ-1:0]   Req = '0;
   logic [8*NREQ-1:0] ReqData = '0;
   logic              TxDone = 1'b0;
   logic [NREQ-1:0]   Ack;
   logic              TxEn;
   logic [7:0]        TxData;
   logic              Busy;
   logic [2:0]        Owner;
   logic              Err;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(
      .NREQ      (NREQ),
      .GAP_CYCLES(GAP),
      .TIMEOUT   (TMO)
   ) dut (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .Req    (Req),
      .ReqData(ReqData),
      .Ack    (Ack),
      .TxEn   (TxEn),
      .TxData (TxData),
      .TxDone (TxDone),
      .Busy   (Busy),
      .Owner  (Owner),
      .Err    (Err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Model: a frame is described by its grant edge and its end edge.
   int              cyc = 0;
   int              f_start = 0;
   int              rel_at = 0;
   int              m_ptr = 0;
   bit              ended = 0;
   logic [NREQ-1:0] e_ack = '0;
   logic            e_txen = 0;
   logic            e_busy = 0;
   logic            e_err = 0;
   logic [7:0]      e_data = '0;
   logic [2:0]      e_owner = '0;

   always @(posedge Clk) begin
      logic [NREQ-1:0] prev_ack;
      logic [NREQ-1:0] elig;
      int w;
      int idx;
      cyc++;
      prev_ack = e_ack;
      e_txen = 0;
      e_ack = '0;
      e_err = 0;
      if (!Rst_n) begin
         e_busy = 0;
         e_data = '0;
         e_owner = '0;
         m_ptr = 0;
         ended = 0;
      end else if (e_busy) begin
         if (!ended && cyc >= f_start + 2) begin
            if (TxDone) begin
               e_ack = NREQ'(1) << e_owner;
               ended = 1;
            end else if (cyc == f_start + 1 + TMO) begin
               e_err = 1;
               ended = 1;
            end
            if (ended) begin
               m_ptr = (int'(e_owner) + 1) % NREQ;
               rel_at = cyc + GAP;
            end
         end
         if (ended && cyc == rel_at) begin
            e_busy = 0;
            ended = 0;
         end
      end else begin
         elig = Req & ~prev_ack;
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && ((elig >> idx) & NREQ'(1)) != '0) w = idx;
         end
         if (w >= 0) begin
            e_busy = 1;
            e_owner = 3'(w);
            e_data = 8'(ReqData >> (8 * w));
            e_txen = 1;
            f_start = cyc;
         end
      end
      #1;
      chk("TxEn", TxEn, e_txen);
      chk("TxData", TxData, e_data);
      chk("Owner", Owner, e_owner);
      chk("Ack", Ack, e_ack);
      chk("Busy", Busy, e_busy);
      chk("Err", Err, e_err);
   end

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic set_data(input int i, input logic [7:0] b);
      logic [8*NREQ-1:0] bm;
      bm = (8*NREQ)'(8'hFF) << (8 * i);
      ReqData = (ReqData & ~bm) | ((8*NREQ)'(b) << (8 * i));
   endtask

   task automatic wait_txen(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (TxEn !== 1'b1 && n < 200);
      chk("txen_seen", TxEn, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (Busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      chk("idle_seen", Busy, 0);
   endtask

   task automatic rand_step();
      logic [NREQ-1:0] r;
      logic [NREQ-1:0] m;
      r = Req;
      for (int i = 0; i < NREQ; i++) begin
         m = NREQ'(1) << i;
         if ((e_ack & m) != '0) begin
            if ($urandom % 2 == 0) r = r & ~m;
            else set_data(i, 8'($urandom));
         end else if ((r & m) == '0) begin
            if ($urandom % 4 == 0) begin
               r = r | m;
               set_data(i, 8'($urandom));
            end
         end else if ($urandom % 40 == 0) begin
            r = r & ~m;
         end else if ($urandom % 16 == 0) begin
            set_data(i, 8'($urandom));
         end
      end
      Req = r;
      TxDone = ($urandom % 6 == 0);
   endtask

   logic [7:0] exp_d [4] = '{8'h22, 8'h11, 8'h22, 8'h11};
   logic [2:0] exp_o [4] = '{3'd1, 3'd0, 3'd1, 3'd0};

   initial begin
      int n;
      tick();
      tick();
      tick();
      chk("rst_TxData", TxData, 8'h00);
      chk("rst_Busy", Busy, 0);
      chk("rst_TxEn", TxEn, 0);
      chk("rst_Ack", Ack, 0);
      Rst_n = 1'b1;
      tick();

      // single request, TxDone during LOAD is ignored
      Req = 3'b001;
      set_data(0, 8'hA5);
      tick();
      chk("single_txen", TxEn, 1);
      chk("single_data", TxData, 8'hA5);
      chk("single_owner", Owner, 0);
      chk("single_busy", Busy, 1);
      TxDone = 1'b1;
      tick();
      chk("single_txen_off", TxEn, 0);
      chk("early_done_no_ack", Ack, 0);
      TxDone = 1'b0;
      tick();
      TxDone = 1'b1;
      tick();
      chk("single_ack", Ack, 3'b001);
      chk("single_no_err", Err, 0);
      TxDone = 1'b0;
      Req = '0;
      n = 0;
      while (Busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("gap_busy_len", n, GAP);

      // contention: two sources held high alternate
      Req = 3'b011;
      set_data(0, 8'h11);
      set_data(1, 8'h22);
      for (int f = 0; f < 4; f++) begin
         wait_txen(n);
         if (f > 0) chk("rr_gap", n, GAP + 1);
         chk("rr_data", TxData, exp_d[f]);
         chk("rr_owner", Owner, exp_o[f]);
         tick();
         TxDone = 1'b1;
         tick();
         TxDone = 1'b0;
         chk("rr_ack", Ack, NREQ'(1) << exp_o[f]);
      end
      Req = '0;
      wait_idle();

      // timeout, then pointer moves on to requester 1
      Req = 3'b001;
      set_data(0, 8'h33);
      wait_txen(n);
      chk("tmo_owner", Owner, 0);
      n = 0;
      do begin
         tick();
         n++;
      end while (Err !== 1'b1 && n < 300);
      chk("tmo_latency", n, TMO + 1);
      chk("tmo_no_ack", Ack, 0);
      Req = 3'b011;
      set_data(1, 8'h44);
      wait_txen(n);
      chk("tmo_next_owner", Owner, 1);
      chk("tmo_next_data", TxData, 8'h44);

      // reset while waiting for TxDone
      tick();
      tick();
      Rst_n = 1'b0;
      Req = '0;
      tick();
      chk("midrst_busy", Busy, 0);
      chk("midrst_data", TxData, 8'h00);
      chk("midrst_owner", Owner, 0);
      chk("midrst_err", Err, 0);
      Rst_n = 1'b1;
      TxDone = 1'b1;
      tick();
      chk("late_done_ack", Ack, 0);
      chk("late_done_busy", Busy, 0);
      TxDone = 1'b0;
      tick();
      chk("late_done_ack2", Ack, 0);

      // data latched at grant
      Req = 3'b100;
      set_data(2, 8'h5A);
      wait_txen(n);
      chk("hold_owner", Owner, 2);
      chk("hold_data0", TxData, 8'h5A);
      set_data(2, 8'hFF);
      tick();
      tick();
      tick();
      chk("hold_data1", TxData, 8'h5A);
      TxDone = 1'b1;
      tick();
      chk("hold_ack", Ack, 3'b100);
      chk("hold_data2", TxData, 8'h5A);
      TxDone = 1'b0;
      Req = '0;
      wait_idle();

      // pointer wraps from 2 back to 0
      Req = 3'b011;
      set_data(0, 8'h66);
      set_data(1, 8'h77);
      wait_txen(n);
      chk("wrap_owner", Owner, 0);
      chk("wrap_data", TxData, 8'h66);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         tick();
         rand_step();
         Rst_n = (i != 2000);
      end
      Req = '0;
      TxDone = 1'b0;
      Rst_n = 1'b1;
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
